// File: rtl/regfile_pc_flags.sv
// General register file with the top register doubling as the PC, plus carry/zero flags.
// Optional write-through read bypass is enabled with macro REGFILE_BYPASS_EN.
module regfile_pc_flags #(
   parameter int WIDTH = 16,
   parameter int NREGS = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [$clog2(NREGS)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(NREGS)-1:0] rd_addr_a,
   input  logic [$clog2(NREGS)-1:0] rd_addr_b,
   output logic [WIDTH-1:0]         rd_data_a,
   output logic [WIDTH-1:0]         rd_data_b,
   input  logic                     pc_wr,
   input  logic [WIDTH-1:0]         pc_in,
   output logic [WIDTH-1:0]         pc_out,
   input  logic [1:0]               flag_wr,
   input  logic [1:0]               flag_in,
   output logic [1:0]               flag_out
);

   localparam int AW = $clog2(NREGS);

   logic [WIDTH-1:0] regs_r [NREGS];
   logic [1:0]       flags_r;
   logic [WIDTH-1:0] rd_a_s;
   logic [WIDTH-1:0] rd_b_s;

   // Register array; the general port takes priority over pc_wr on the PC slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (wr_en && (wr_addr == AW'(i))) begin
               regs_r[i] <= wr_data;
            end else if (pc_wr && (i == NREGS - 1)) begin
               regs_r[i] <= pc_in;
            end else begin
               regs_r[i] <= regs_r[i];
            end
         end
      end
   end

   // Flag register with independent per-bit enables.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_r <= 2'b00;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (flag_wr[i]) begin
               flags_r[i] <= flag_in[i];
            end else begin
               flags_r[i] <= flags_r[i];
            end
         end
      end
   end

   // Combinational read ports; bypass is gated by rst_n so reads stay zero in reset.
   always_comb begin
      rd_a_s = regs_r[rd_addr_a];
      rd_b_s = regs_r[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
      if (rst_n && wr_en && (wr_addr == rd_addr_a)) begin
         rd_a_s = wr_data;
      end else begin
         rd_a_s = regs_r[rd_addr_a];
      end
      if (rst_n && wr_en && (wr_addr == rd_addr_b)) begin
         rd_b_s = wr_data;
      end else begin
         rd_b_s = regs_r[rd_addr_b];
      end
`endif
   end

   assign rd_data_a = rd_a_s;
   assign rd_data_b = rd_b_s;
   assign pc_out    = regs_r[NREGS-1];
   assign flag_out  = flags_r;

endmodule

// File: tb/tb_regfile_pc_flags.sv
// Directed bench for regfile_pc_flags: array-based reference model checked every cycle
// plus literal expectations; a second 32x16 instance covers the wide configuration.
module tb_regfile_pc_flags;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [2:0]  wr_addr = 3'd0;
   logic [15:0] wr_data = 16'h0000;
   logic [2:0]  rd_addr_a = 3'd0;
   logic [2:0]  rd_addr_b = 3'd0;
   logic [15:0] rd_data_a, rd_data_b, pc_out;
   logic        pc_wr = 1'b0;
   logic [15:0] pc_in = 16'h0000;
   logic [1:0]  flag_wr = 2'b00;
   logic [1:0]  flag_in = 2'b00;
   logic [1:0]  flag_out;

   logic        b_wr_en = 1'b0;
   logic [3:0]  b_wr_addr = 4'd0;
   logic [31:0] b_wr_data = 32'h0;
   logic [3:0]  b_rd_addr_a = 4'd0;
   logic [3:0]  b_rd_addr_b = 4'd0;
   logic [31:0] b_rd_data_a, b_rd_data_b, b_pc_out;
   logic        b_pc_wr = 1'b0;
   logic [31:0] b_pc_in = 32'h0;
   logic [1:0]  b_flag_wr = 2'b00;
   logic [1:0]  b_flag_in = 2'b00;
   logic [1:0]  b_flag_out;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_on  = 1'b1;

   logic [15:0] m_regs [8];
   logic [1:0]  m_flags;

   always #5 clk = ~clk;

   regfile_pc_flags dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .pc_wr(pc_wr), .pc_in(pc_in), .pc_out(pc_out),
      .flag_wr(flag_wr), .flag_in(flag_in), .flag_out(flag_out)
   );

   regfile_pc_flags #(.WIDTH(32), .NREGS(16)) dut_big (
      .clk(clk), .rst_n(rst_n), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .rd_addr_a(b_rd_addr_a), .rd_addr_b(b_rd_addr_b), .rd_data_a(b_rd_data_a), .rd_data_b(b_rd_data_b),
      .pc_wr(b_pc_wr), .pc_in(b_pc_in), .pc_out(b_pc_out),
      .flag_wr(b_flag_wr), .flag_in(b_flag_in), .flag_out(b_flag_out)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the last write in program order wins, so the general port
   // overrides a PC load to the same register.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) m_regs[i] <= 16'h0000;
         m_flags <= 2'b00;
      end else begin
         if (pc_wr) m_regs[7] <= pc_in;
         if (wr_en) m_regs[wr_addr] <= wr_data;
         for (int i = 0; i < 2; i++)
            if (flag_wr[i]) m_flags[i] <= flag_in[i];
      end
   end

   function automatic logic [15:0] exp_rd(input logic [2:0] a);
      if (!rst_n) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (wr_addr == a)) return wr_data;
`endif
      return m_regs[a];
   endfunction

   // Per-cycle comparison, sampled between the input change and the next rising edge.
   always begin
      @(negedge clk);
      #3;
      if (chk_on) begin
         check("model_rd_a", {16'h0, rd_data_a}, {16'h0, exp_rd(rd_addr_a)});
         check("model_rd_b", {16'h0, rd_data_b}, {16'h0, exp_rd(rd_addr_b)});
         check("model_pc",   {16'h0, pc_out},    {16'h0, m_regs[7]});
         check("model_flag", {30'h0, flag_out},  {30'h0, m_flags});
      end
   end

   // Apply one cycle of stimulus just after the falling edge.
   task automatic cyc(input logic rn, input logic we, input logic [2:0] wa, input logic [15:0] wd,
                      input logic [2:0] ra, input logic [2:0] rb, input logic pw, input logic [15:0] pi,
                      input logic [1:0] fw, input logic [1:0] fi);
      @(negedge clk);
      #1;
      rst_n = rn; wr_en = we; wr_addr = wa; wr_data = wd; rd_addr_a = ra; rd_addr_b = rb;
      pc_wr = pw; pc_in = pi; flag_wr = fw; flag_in = fi;
   endtask

   initial begin
      // Writes during reset are ignored and every output reads zero.
      cyc(1'b0, 1'b1, 3'd3, 16'hFFFF, 3'd3, 3'd7, 1'b1, 16'h1111, 2'b11, 2'b11);
      #2;
      check("reset_rd_a", {16'h0, rd_data_a}, 32'h0);
      check("reset_pc",   {16'h0, pc_out},    32'h0);
      check("reset_flag", {30'h0, flag_out},  32'h0);

      // Release reset with a write on the same edge; then read it on both ports.
      cyc(1'b1, 1'b1, 3'd3, 16'hBEEF, 3'd0, 3'd0, 1'b0, 16'h0000, 2'b00, 2'b00);
      cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3, 1'b0, 16'h0000, 2'b00, 2'b00);
      #2;
      check("wr_rd_a", {16'h0, rd_data_a}, 32'h0000BEEF);
      check("wr_rd_b", {16'h0, rd_data_b}, 32'h0000BEEF);

      // PC collision: general port wins.
      cyc(1'b1, 1'b1, 3'd7, 16'h1234, 3'd0, 3'd0, 1'b1, 16'h0042, 2'b00, 2'b00);
      cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd7, 3'd0, 1'b0, 16'h0000, 2'b00, 2'b00);
      #2;
      check("pc_collision", {16'h0, pc_out}, 32'h00001234);

      // General write elsewhere and PC load on the same edge.
      cyc(1'b1, 1'b1, 3'd2, 16'h5555, 3'd0, 3'd0, 1'b1, 16'h0100, 2'b00, 2'b00);
      cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd7, 1'b0, 16'h0000, 2'b00, 2'b00);
      #2;
      check("dual_wr_reg", {16'h0, rd_data_a}, 32'h00005555);
      check("dual_wr_pc",  {16'h0, pc_out},    32'h00000100);

      // Register 0 is ordinary storage.
      cyc(1'b1, 1'b1, 3'd0, 16'hA5A5, 3'd1, 3'd1, 1'b0, 16'h0000, 2'b00, 2'b00);
      cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, 16'h0000, 2'b00, 2'b00);
      #2;
      check("reg0_writable", {16'h0, rd_data_b}, 32'h0000A5A5);

      // Flag bits load independently.
      cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, 16'h0000, 2'b01, 2'b11);
      cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, 16'h0000, 2'b10, 2'b00);
      #2;
      check("flag_carry", {30'h0, flag_out}, 32'h1);
      cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, 16'h0000, 2'b10, 2'b10);
      cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, 16'h0000, 2'b01, 2'b00);
      #2;
      check("flag_both", {30'h0, flag_out}, 32'h3);
      cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0, 16'h0000, 2'b00, 2'b11);
      #2;
      check("flag_zero_only", {30'h0, flag_out}, 32'h2);

      // Same-cycle read of the register being written.
      cyc(1'b1, 1'b1, 3'd5, 16'h0001, 3'd0, 3'd0, 1'b0, 16'h0000, 2'b00, 2'b00);
      cyc(1'b1, 1'b1, 3'd5, 16'h00FF, 3'd5, 3'd4, 1'b0, 16'h0000, 2'b00, 2'b00);
      #2;
`ifdef REGFILE_BYPASS_EN
      check("bypass_rd_a", {16'h0, rd_data_a}, 32'h000000FF);
`else
      check("bypass_rd_a", {16'h0, rd_data_a}, 32'h00000001);
`endif
      cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 1'b0, 16'h0000, 2'b00, 2'b00);
      #2;
      check("after_edge_rd", {16'h0, rd_data_b}, 32'h000000FF);

      // A PC-only load never bypasses to a read port or pc_out.
      cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd7, 3'd7, 1'b1, 16'h0777, 2'b00, 2'b00);
      #2;
      check("pc_no_bypass_rd", {16'h0, rd_data_a}, 32'h00000100);
      check("pc_no_bypass_out", {16'h0, pc_out},   32'h00000100);

      // Sweep every register with distinct data.
      for (int i = 0; i < 8; i++)
         cyc(1'b1, 1'b1, 3'(i), 16'h1111 * 16'(i) + 16'h0001, 3'(7 - i), 3'(i), 1'b0, 16'h0000, 2'b00, 2'b00);
      for (int i = 0; i < 8; i++)
         cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i), 1'b0, 16'h0000, 2'b00, 2'b00);
      #2;
      check("sweep_rd_a7", {16'h0, rd_data_a}, 32'h00007778);

      // Mid-cycle reset clears everything before the next edge, bypass included.
      cyc(1'b0, 1'b1, 3'd3, 16'hFFFF, 3'd3, 3'd6, 1'b0, 16'h0000, 2'b00, 2'b00);
      #2;
      check("midrst_rd_a", {16'h0, rd_data_a}, 32'h0);
      check("midrst_rd_b", {16'h0, rd_data_b}, 32'h0);
      check("midrst_pc",   {16'h0, pc_out},    32'h0);
      check("midrst_flag", {30'h0, flag_out},  32'h0);
      cyc(1'b1, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd7, 1'b0, 16'h0000, 2'b00, 2'b00);
      #2;
      check("postrst_rd", {16'h0, rd_data_a}, 32'h0);

      // Wide configuration: PC load to register 15.
      @(negedge clk);
      #1;
      b_pc_wr = 1'b1; b_pc_in = 32'hDEADBEEF; b_rd_addr_a = 4'd15; b_rd_addr_b = 4'd0;
      @(negedge clk);
      #1;
      b_pc_wr = 1'b0;
      #2;
      check("big_pc_out", b_pc_out,    32'hDEADBEEF);
      check("big_rd_a15", b_rd_data_a, 32'hDEADBEEF);
      check("big_rd_b0",  b_rd_data_b, 32'h0);

      @(negedge clk);
      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
